// File: rtl/rat_ckpt_if.sv
// ---------------------------------------------------------------------------
// rat_ckpt_if -- rename / checkpoint / recovery bus of the register alias
// table (rat_ckpt).
//
// The rename stage (master) drives one rename group per cycle. It also drives
// the checkpoint allocate/release requests and both recovery requests. The RAT
// (slave) returns the combinational source and previous-destination mappings
// and the checkpoint status.
//
// Signals (slot i of a packed per-slot field sits at [W*i +: W]):
//   ren_valid, ren_rd_exist        per-slot rename valid / destination present
//   ren_rd_idx, ren_rj_idx,
//   ren_rk_idx                     architectural indices, 5 bits per slot
//   ren_new_preg                   newly allocated preg per slot
//   rd_old_preg, rj_preg, rk_preg  previous rd mapping / source mappings
//   ckpt_req, ckpt_slot            snapshot request, last slot it includes
//   ckpt_id, ckpt_full             id granted (current tail) / no free slot
//   ckpt_release                   free the oldest checkpoint
//   recover_ckpt_valid/_id         restore from a checkpoint (mispredict)
//   recover_arch_valid/_map        load the committed map (exception)
// ---------------------------------------------------------------------------
interface rat_ckpt_if #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 7,
  parameter int RW        = 4,
  parameter int CKPT_NUM  = 4
);
  localparam int CW = $clog2(CKPT_NUM);
  localparam int SW = $clog2(RW);

  logic [RW-1:0]                  ren_valid;
  logic [RW-1:0]                  ren_rd_exist;
  logic [RW*5-1:0]                ren_rd_idx;
  logic [RW*5-1:0]                ren_rj_idx;
  logic [RW*5-1:0]                ren_rk_idx;
  logic [RW*PREG_W-1:0]           ren_new_preg;
  logic [RW*PREG_W-1:0]           rd_old_preg;
  logic [RW*PREG_W-1:0]           rj_preg;
  logic [RW*PREG_W-1:0]           rk_preg;
  logic                           ckpt_req;
  logic [SW-1:0]                  ckpt_slot;
  logic [CW-1:0]                  ckpt_id;
  logic                           ckpt_full;
  logic                           ckpt_release;
  logic                           recover_ckpt_valid;
  logic [CW-1:0]                  recover_ckpt_id;
  logic                           recover_arch_valid;
  logic [ARCH_REGS*PREG_W-1:0]    recover_arch_map;

  modport master (
    output ren_valid, ren_rd_exist, ren_rd_idx, ren_rj_idx, ren_rk_idx,
    output ren_new_preg, ckpt_req, ckpt_slot, ckpt_release,
    output recover_ckpt_valid, recover_ckpt_id,
    output recover_arch_valid, recover_arch_map,
    input  rd_old_preg, rj_preg, rk_preg, ckpt_id, ckpt_full
  );

  modport slave (
    input  ren_valid, ren_rd_exist, ren_rd_idx, ren_rj_idx, ren_rk_idx,
    input  ren_new_preg, ckpt_req, ckpt_slot, ckpt_release,
    input  recover_ckpt_valid, recover_ckpt_id,
    input  recover_arch_valid, recover_arch_map,
    output rd_old_preg, rj_preg, rk_preg, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/rat_ckpt.sv
// ---------------------------------------------------------------------------
// rat_ckpt -- register alias table with a circular buffer of checkpoints.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (identity map, no live checkpoints)
//   bus   rat_ckpt_if.slave: rename group, checkpoint and recovery traffic
//
// Lookups are combinational from the current table. Renames of the group
// update the table at the clock edge, with the youngest slot winning when
// several slots write the same rd. A checkpoint captures the table as seen
// after slots 0..ckpt_slot only. Checkpoints live in a FIFO (head = oldest,
// tail = next id to grant). Priority at the edge:
//   rst > recover_arch > recover_ckpt (live id) > rename/allocate/release.
//
// Optional feature: define RAT_GROUP_BYPASS_EN to forward destinations
// written by older slots of the same group to the lookups of younger slots.
// Without it every lookup reads the table only, and the rename stage splits
// groups that carry an intra-group RAW/WAW dependency.
// ---------------------------------------------------------------------------
module rat_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 7,
  parameter int RW        = 4,
  parameter int CKPT_NUM  = 4
) (
  input  logic      clk,
  input  logic      rst,
  rat_ckpt_if.slave bus
);
  localparam int IW = 5;
  localparam int CW = $clog2(CKPT_NUM);

  typedef logic [ARCH_REGS-1:0][PREG_W-1:0] map_t;

  map_t                        rmap_q;
  map_t                        rmap_upd;
  map_t                        rmap_snap;
  map_t                        arch_map;
  map_t                        ckpt_q [CKPT_NUM];

  logic [CW-1:0]               head_q;
  logic [CW-1:0]               tail_q;
  logic [CW:0]                 count_q;
  logic [CW-1:0]               rec_off;

  logic [RW-1:0][IW-1:0]       rd_idx;
  logic [RW-1:0][IW-1:0]       rj_idx;
  logic [RW-1:0][IW-1:0]       rk_idx;
  logic [RW-1:0][PREG_W-1:0]   new_preg;
  logic [RW-1:0][PREG_W-1:0]   rj_map;
  logic [RW-1:0][PREG_W-1:0]   rk_map;
  logic [RW-1:0][PREG_W-1:0]   rd_map;
  logic [RW-1:0]               wr_en;

  logic                        full;
  logic                        rel_ok;
  logic                        alloc;
  logic                        rec_live;
  logic                        ckpt_wr;

  assign rd_idx   = bus.ren_rd_idx;
  assign rj_idx   = bus.ren_rj_idx;
  assign rk_idx   = bus.ren_rk_idx;
  assign new_preg = bus.ren_new_preg;
  assign arch_map = bus.recover_arch_map;

  // Writes to arch register 0 are dropped so entry 0 stays hard-wired to 0.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < RW; i++)
      wr_en[i] = bus.ren_valid[i] & bus.ren_rd_exist[i] & (rd_idx[i] != '0);
  end

  // Slots are applied oldest first so the youngest writer of an rd wins. The
  // snapshot only sees the slots up to and including ckpt_slot.
  always_comb begin
    rmap_upd  = rmap_q;
    rmap_snap = rmap_q;
    for (int i = 0; i < RW; i++) begin
      if (wr_en[i]) begin
        rmap_upd[rd_idx[i]] = new_preg[i];
        if (i <= int'(bus.ckpt_slot))
          rmap_snap[rd_idx[i]] = new_preg[i];
      end
    end
  end

  always_comb begin
    rj_map = '0;
    rk_map = '0;
    rd_map = '0;
    for (int i = 0; i < RW; i++) begin
      rj_map[i] = rmap_q[rj_idx[i]];
      rk_map[i] = rmap_q[rk_idx[i]];
      rd_map[i] = rmap_q[rd_idx[i]];
`ifdef RAT_GROUP_BYPASS_EN
      // Ascending scan: the youngest older writer is the last one to hit.
      for (int j = 0; j < i; j++) begin
        if (wr_en[j] && rd_idx[j] == rj_idx[i]) rj_map[i] = new_preg[j];
        if (wr_en[j] && rd_idx[j] == rk_idx[i]) rk_map[i] = new_preg[j];
        if (wr_en[j] && rd_idx[j] == rd_idx[i]) rd_map[i] = new_preg[j];
      end
`endif
      if (!bus.ren_valid[i] || rj_idx[i] == '0) rj_map[i] = '0;
      if (!bus.ren_valid[i] || rk_idx[i] == '0) rk_map[i] = '0;
      if (!bus.ren_valid[i] || !bus.ren_rd_exist[i] || rd_idx[i] == '0)
        rd_map[i] = '0;
    end
  end

  assign bus.rj_preg     = rj_map;
  assign bus.rk_preg     = rk_map;
  assign bus.rd_old_preg = rd_map;

  assign full   = (count_q == (CW+1)'(CKPT_NUM));
  assign rel_ok = bus.ckpt_release && (count_q != '0);
  // A release in the same cycle frees the head slot, which the tail then
  // reuses, so an allocation is still accepted when the buffer is full.
  assign alloc  = bus.ckpt_req && (!full || rel_ok);

  // An id is live when its distance from head is below the occupancy.
  assign rec_off  = bus.recover_ckpt_id - head_q;
  assign rec_live = bus.recover_ckpt_valid && ({1'b0, rec_off} < count_q);

  assign ckpt_wr = !rst && !bus.recover_arch_valid && !rec_live && alloc;

  assign bus.ckpt_full = full;
  assign bus.ckpt_id   = tail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ARCH_REGS; r++)
        rmap_q[r] <= PREG_W'(r);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.recover_arch_valid) begin
      for (int r = 0; r < ARCH_REGS; r++)
        rmap_q[r] <= (r == 0) ? '0 : arch_map[r];
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rec_live) begin
      // The recovered checkpoint and everything younger are freed.
      rmap_q  <= ckpt_q[bus.recover_ckpt_id];
      tail_q  <= bus.recover_ckpt_id;
      count_q <= {1'b0, rec_off};
    end else begin
      rmap_q <= rmap_upd;
      if (alloc)  tail_q <= tail_q + CW'(1);
      if (rel_ok) head_q <= head_q + CW'(1);
      count_q <= count_q + (CW+1)'(alloc) - (CW+1)'(rel_ok);
    end
  end

  // Snapshot storage carries no reset; only live entries are ever read.
  always_ff @(posedge clk) begin
    if (ckpt_wr)
      ckpt_q[tail_q] <= rmap_snap;
  end
endmodule

// File: tb/tb_rat_ckpt.sv
// ---------------------------------------------------------------------------
// tb_rat_ckpt -- self-checking bench for rat_ckpt.
// Reference model: the map is a plain array, and the live checkpoints are a
// queue of whole-map snapshots (front = oldest). Ids are derived from a head
// counter plus the queue position.
// ---------------------------------------------------------------------------
module tb_rat_ckpt;
  localparam int ARCH_REGS = 32;
  localparam int PREG_W    = 7;
  localparam int RW        = 4;
  localparam int CKPT_NUM  = 4;

  typedef logic [ARCH_REGS-1:0][PREG_W-1:0] snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rat_ckpt_if #(.ARCH_REGS(ARCH_REGS), .PREG_W(PREG_W), .RW(RW),
                .CKPT_NUM(CKPT_NUM)) bus ();

  rat_ckpt #(.ARCH_REGS(ARCH_REGS), .PREG_W(PREG_W), .RW(RW),
             .CKPT_NUM(CKPT_NUM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic [RW-1:0] s_valid, s_exist;
  int            s_rd [RW];
  int            s_rj [RW];
  int            s_rk [RW];
  int            s_new[RW];
  logic          c_req, c_rel, c_rec, c_arch;
  int            c_slot, c_rec_id;
  snap_t         c_map;

  // Reference model
  snap_t m_tbl;
  snap_t m_ck[$];
  int    m_head;

  always @(posedge clk)
    assert (!(bus.ckpt_release && bus.recover_ckpt_valid))
      else $error("illegal stimulus: release together with checkpoint recovery");

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic clear();
    s_valid = '0; s_exist = '0;
    for (int i = 0; i < RW; i++) begin
      s_rd[i] = 0; s_rj[i] = 0; s_rk[i] = 0; s_new[i] = 0;
    end
    c_req = 0; c_rel = 0; c_rec = 0; c_arch = 0;
    c_slot = 0; c_rec_id = 0; c_map = '0;
  endtask

  task automatic drive();
    bus.ren_valid    = s_valid;
    bus.ren_rd_exist = s_exist;
    for (int i = 0; i < RW; i++) begin
      bus.ren_rd_idx[i*5 +: 5]            = 5'(s_rd[i]);
      bus.ren_rj_idx[i*5 +: 5]            = 5'(s_rj[i]);
      bus.ren_rk_idx[i*5 +: 5]            = 5'(s_rk[i]);
      bus.ren_new_preg[i*PREG_W +: PREG_W] = PREG_W'(s_new[i]);
    end
    bus.ckpt_req           = c_req;
    bus.ckpt_slot          = 2'(c_slot);
    bus.ckpt_release       = c_rel;
    bus.recover_ckpt_valid = c_rec;
    bus.recover_ckpt_id    = 2'(c_rec_id);
    bus.recover_arch_valid = c_arch;
    bus.recover_arch_map   = c_map;
  endtask

  function automatic logic [PREG_W-1:0] exp_src(int slot, int idx);
    logic [PREG_W-1:0] r;
    if (!s_valid[slot] || idx == 0) return '0;
    r = m_tbl[idx];
`ifdef RAT_GROUP_BYPASS_EN
    for (int j = 0; j < slot; j++)
      if (s_valid[j] && s_exist[j] && s_rd[j] == idx) r = PREG_W'(s_new[j]);
`endif
    return r;
  endfunction

  function automatic logic [PREG_W-1:0] exp_old(int slot);
    if (!s_exist[slot]) return '0;
    return exp_src(slot, s_rd[slot]);
  endfunction

  function automatic logic [PREG_W-1:0] rj_of(int slot);
    return bus.rj_preg[slot*PREG_W +: PREG_W];
  endfunction

  task automatic check_outputs(input string tag);
    #1;
    for (int i = 0; i < RW; i++) begin
      chk($sformatf("%s rj[%0d]", tag, i), bus.rj_preg[i*PREG_W +: PREG_W], exp_src(i, s_rj[i]));
      chk($sformatf("%s rk[%0d]", tag, i), bus.rk_preg[i*PREG_W +: PREG_W], exp_src(i, s_rk[i]));
      chk($sformatf("%s rd_old[%0d]", tag, i), bus.rd_old_preg[i*PREG_W +: PREG_W], exp_old(i));
    end
    chk({tag, " ckpt_full"}, bus.ckpt_full, m_ck.size() == CKPT_NUM);
    chk({tag, " ckpt_id"}, bus.ckpt_id, (m_head + m_ck.size()) % CKPT_NUM);
  endtask

  // Reads every architectural register through the rj/rk ports.
  task automatic read_table(input string tag);
    for (int k = 0; k < ARCH_REGS / (2*RW); k++) begin
      clear();
      for (int s = 0; s < RW; s++) begin
        s_valid[s] = 1'b1;
        s_rj[s] = 8*k + 2*s;
        s_rk[s] = 8*k + 2*s + 1;
      end
      drive();
      check_outputs(tag);
    end
    clear();
    drive();
  endtask

  task automatic model_apply();
    snap_t snap;
    int    pos;
    logic  full, rel_ok, alloc;
    if (rst) begin
      for (int r = 0; r < ARCH_REGS; r++) m_tbl[r] = PREG_W'(r);
      m_ck.delete();
      m_head = 0;
    end else if (c_arch) begin
      m_tbl = c_map;
      m_tbl[0] = '0;
      m_ck.delete();
      m_head = 0;
    end else begin
      pos = (c_rec_id - m_head + CKPT_NUM) % CKPT_NUM;
      if (c_rec && pos < int'(m_ck.size())) begin
        m_tbl = m_ck[pos];
        while (int'(m_ck.size()) > pos) void'(m_ck.pop_back());
      end else begin
        snap = m_tbl;
        for (int i = 0; i < RW; i++) begin
          if (s_valid[i] && s_exist[i] && s_rd[i] != 0) begin
            m_tbl[s_rd[i]] = PREG_W'(s_new[i]);
            if (i <= c_slot) snap[s_rd[i]] = PREG_W'(s_new[i]);
          end
        end
        full   = (m_ck.size() == CKPT_NUM);
        rel_ok = c_rel && (m_ck.size() > 0);
        alloc  = c_req && (!full || rel_ok);
        if (rel_ok) begin
          void'(m_ck.pop_front());
          m_head = (m_head + 1) % CKPT_NUM;
        end
        if (alloc) m_ck.push_back(snap);
      end
    end
  endtask

  task automatic tick();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear();
    drive();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m_head = 0;
    do_reset();

    // Reset state and identity map
    read_table("reset");
    chk("reset ckpt_full", bus.ckpt_full, 1'b0);
    chk("reset ckpt_id", bus.ckpt_id, 0);

    clear(); s_valid[0] = 1; s_rj[0] = 5; drive();
    check_outputs("rj5");
    chk("rj5 explicit", rj_of(0), 5);

    // rd=0 writes are dropped
    clear(); s_valid[0] = 1; s_exist[0] = 1; s_rd[0] = 0; s_new[0] = 40; drive();
    check_outputs("rd0 write");
    tick();
    read_table("after rd0");

    // Intra-group RAW/WAW
    clear();
    s_valid = 4'b0011; s_exist = 4'b0011;
    s_rd[0] = 3; s_new[0] = 40;
    s_rj[1] = 3; s_rd[1] = 3; s_new[1] = 41;
    drive();
    check_outputs("group dep");
`ifdef RAT_GROUP_BYPASS_EN
    chk("bypass rj[1]", rj_of(1), 40);
    chk("bypass rd_old[1]", bus.rd_old_preg[PREG_W +: PREG_W], 40);
`endif
    tick();
    clear(); s_valid[0] = 1; s_rj[0] = 3; drive();
    check_outputs("waw result");
    chk("table3 youngest", rj_of(0), 41);

    // Partial-group snapshot, then recovery from it
    do_reset();
    clear();
    s_valid = 4'b0011; s_exist = 4'b0011;
    s_rd[0] = 7; s_new[0] = 50; s_rd[1] = 7; s_new[1] = 51;
    c_req = 1; c_slot = 0;
    drive();
    check_outputs("ckpt alloc");
    chk("ckpt granted id", bus.ckpt_id, 0);
    tick();
    clear(); s_valid[0] = 1; s_rj[0] = 7; drive();
    check_outputs("table7 live");
    chk("table7 live explicit", rj_of(0), 51);
    clear();
    c_rec = 1; c_rec_id = 0;
    s_valid[0] = 1; s_exist[0] = 1; s_rd[0] = 7; s_new[0] = 60; c_req = 1;
    drive();
    check_outputs("recover ckpt0");
    tick();
    clear(); s_valid[0] = 1; s_rj[0] = 7; drive();
    check_outputs("after recover");
    chk("table7 restored", rj_of(0), 50);
    chk("recover count0 full", bus.ckpt_full, 1'b0);
    chk("recover tail", bus.ckpt_id, 0);

    // Fill, overflow request, release+allocate when full
    for (int a = 0; a < CKPT_NUM; a++) begin
      clear(); c_req = 1; c_slot = 3;
      s_valid[0] = 1; s_exist[0] = 1; s_rd[0] = 10 + a; s_new[0] = 70 + a;
      drive();
      check_outputs("fill");
      chk($sformatf("fill id %0d", a), bus.ckpt_id, a);
      tick();
    end
    clear(); drive(); #1;
    chk("full after 4", bus.ckpt_full, 1'b1);
    clear(); c_req = 1; drive();
    check_outputs("fifth req");
    tick();
    clear(); drive();
    check_outputs("fifth ignored");
    clear(); c_req = 1; c_rel = 1; drive();
    tick();
    clear(); drive();
    check_outputs("rel+alloc");
    chk("rel+alloc still full", bus.ckpt_full, 1'b1);
    chk("rel+alloc tail", bus.ckpt_id, 1);
    clear(); c_rel = 1; drive();
    tick();
    clear(); drive();
    check_outputs("release");
    chk("release not full", bus.ckpt_full, 1'b0);

    // Non-live recovery id is ignored
    do_reset();
    clear(); c_req = 1; s_valid[0] = 1; s_exist[0] = 1; s_rd[0] = 4; s_new[0] = 90; drive();
    tick();
    clear(); c_rec = 1; c_rec_id = 2; drive();
    tick();
    clear(); s_valid[0] = 1; s_rj[0] = 4; drive();
    check_outputs("nonlive recover");
    chk("nonlive tail", bus.ckpt_id, 1);
    chk("nonlive table4", rj_of(0), 90);

    // Architectural recovery beats checkpoint recovery
    clear(); c_req = 1; drive(); tick();
    clear();
    c_arch = 1;
    for (int r = 0; r < ARCH_REGS; r++) c_map[r] = PREG_W'(r + 32);
    c_rec = 1; c_rec_id = 0; c_req = 1;
    s_valid[0] = 1; s_exist[0] = 1; s_rd[0] = 5; s_new[0] = 99;
    drive();
    tick();
    read_table("arch recover");
    clear(); s_valid[0] = 1; s_rj[0] = 5; drive(); #1;
    chk("arch table5", rj_of(0), 37);
    chk("arch full", bus.ckpt_full, 1'b0);
    chk("arch tail", bus.ckpt_id, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      clear();
      for (int s = 0; s < RW; s++) begin
        s_valid[s] = 1'($urandom_range(0, 1));
        s_exist[s] = 1'($urandom_range(0, 1));
        s_rd[s]    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
        s_rj[s]    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
        s_rk[s]    = int'($urandom_range(0, 31));
        s_new[s]   = int'($urandom_range(0, 127));
      end
      c_req  = ($urandom_range(0, 9) < 4);
      c_slot = int'($urandom_range(0, 3));
      c_rel  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 14) == 0) begin
        c_rec = 1; c_rel = 0; c_rec_id = int'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 59) == 0) begin
        c_arch = 1;
        for (int r = 0; r < ARCH_REGS; r++) c_map[r] = PREG_W'($urandom_range(0, 127));
      end
      drive();
      check_outputs("rnd");
      tick();
      if (n % 64 == 63) read_table("rnd table");
    end

    // Reset wins over concurrent recovery, rename and checkpoint activity
    clear(); c_req = 1; drive(); tick();
    clear();
    rst = 1'b1;
    c_arch = 1; c_rec = 1; c_rec_id = 0; c_req = 1;
    for (int r = 0; r < ARCH_REGS; r++) c_map[r] = PREG_W'(r + 64);
    s_valid[0] = 1; s_exist[0] = 1; s_rd[0] = 9; s_new[0] = 100;
    drive();
    tick();
    rst = 1'b0;
    read_table("rst mid-recover");
    clear(); s_valid[0] = 1; s_rj[0] = 9; drive(); #1;
    chk("rst table9", rj_of(0), 9);
    chk("rst full", bus.ckpt_full, 1'b0);
    chk("rst tail", bus.ckpt_id, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
